// File: rtl/l1_ingress_fifo_arb.sv
// Layer-1 ingress stage: four per-lane byte FIFOs merged by a round-robin
// arbiter into one registered output stream, with fill/overflow/idle status.
module l1_ingress_fifo_arb #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] L1_in0,
    input  logic [DATA_W-1:0] L1_in1,
    input  logic [DATA_W-1:0] L1_in2,
    input  logic [DATA_W-1:0] L1_in3,
    input  logic              L1_valid0,
    input  logic              L1_valid1,
    input  logic              L1_valid2,
    input  logic              L1_valid3,
    input  logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [1:0]        out_lane,
    output logic [3:0]        empty,
    output logic [3:0]        almost_full,
    output logic [3:0]        overflow,
    output logic              idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] lane_in [4];
    logic [3:0]        lane_valid;
    logic [DATA_W-1:0] mem [4][DEPTH];
    logic [PW-1:0]     wr_ptr [4];
    logic [PW-1:0]     rd_ptr [4];
    logic [CW-1:0]     count [4];
    logic [1:0]        last_grant;
    logic [1:0]        win;
    logic              have;
    logic              pop;
    logic [3:0]        pop_lane;
    logic [3:0]        wr_ok;
    logic [3:0]        drop;

    assign lane_in[0] = L1_in0;
    assign lane_in[1] = L1_in1;
    assign lane_in[2] = L1_in2;
    assign lane_in[3] = L1_in3;
    assign lane_valid = {L1_valid3, L1_valid2, L1_valid1, L1_valid0};

    // Candidates use registered counts, so a byte written this cycle waits an edge.
    always_comb begin
        have = 1'b0;
        win  = last_grant;
        for (int k = 1; k <= 4; k++) begin
            if (!have && count[2'(last_grant + 2'(k))] != '0) begin
                have = 1'b1;
                win  = 2'(last_grant + 2'(k));
            end
        end
    end

    assign pop = ready_in & have;

    always_comb begin
        pop_lane    = '0;
        wr_ok       = '0;
        drop        = '0;
        empty       = '0;
        almost_full = '0;
        for (int i = 0; i < 4; i++) begin
            pop_lane[i]    = pop && (win == 2'(i));
            wr_ok[i]       = lane_valid[i] && ((count[i] != CW'(DEPTH)) || pop_lane[i]);
            drop[i]        = lane_valid[i] && (count[i] == CW'(DEPTH)) && !pop_lane[i];
            empty[i]       = (count[i] == '0);
            almost_full[i] = (count[i] >= CW'(AFULL_TH));
        end
    end

    assign idle = (&empty) & ~valid_out;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!reset && wr_ok[i]) begin
                mem[i][wr_ptr[i]] <= lane_in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            last_grant <= 2'd3;
            data_out   <= '0;
            valid_out  <= 1'b0;
            out_lane   <= 2'd0;
            overflow   <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_ok[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop_lane[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                count[i] <= count[i] + CW'(wr_ok[i]) - CW'(pop_lane[i]);
                if (drop[i]) begin
                    overflow[i] <= 1'b1;
                end
            end
            valid_out <= pop;
            if (pop) begin
                data_out   <= mem[win][rd_ptr[win]];
                out_lane   <= win;
                last_grant <= win;
            end
        end
    end
endmodule

// File: doc/l1_ingress_fifo_arb.md
# l1_ingress_fifo_arb

Layer-1 ingress stage directly downstream of the recirculation router. It receives the four `L1_inN`/`L1_validN` byte lanes (the router output when `IDL`=1) and buffers each lane in its own FIFO. A round-robin arbiter merges the four FIFOs into a single registered byte stream for the next layer. It also exports per-lane fill flags and an `idle` status that the control logic uses to decide when `IDL` may drop.

## Interface
- `DATA_W`, default 8: byte width of every lane and of the output.
- `DEPTH`, default 4: entries per lane FIFO; power of two, ≥2.
- `AFULL_TH`, default 3: `almost_full[i]`=1 when lane i count ≥ `AFULL_TH`; range 1..`DEPTH`.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `L1_in0`..`L1_in3`  input  DATA_W  lane data from the recirculation stage.
- `L1_valid0`..`L1_valid3`  input  1  per-lane write strobe; one byte per cycle when high.
- `ready_in`  input  1  downstream accepts a byte this cycle.
- `data_out`  output  DATA_W  merged byte, registered.
- `valid_out`  output  1  `data_out` holds a byte this cycle.
- `out_lane`  output  2  source lane of `data_out`.
- `empty`  output  4  per-lane FIFO empty (count==0).
- `almost_full`  output  4  per-lane count ≥ `AFULL_TH`.
- `overflow`  output  4  sticky per-lane drop flag.
- `idle`  output  1  all FIFOs empty and `valid_out`=0.

## Operation
- Per lane: circular buffer with write pointer, read pointer and count. Count is `$clog2(DEPTH)+1` bits. Pointers wrap modulo `DEPTH`.
- Write: when `L1_validN`=1, the byte is stored if the lane is not full, or if the lane is full and is popped in the same cycle. In that case the count is unchanged and both pointers advance.
- Drop: when `L1_validN`=1 with the lane full and no pop in the same cycle, the byte is discarded and `overflow[N]` is set. It stays set until `reset`.
- Arbiter: `last_grant` is a 2-bit register. Candidates are the lanes with count>0, taken before any write in the current cycle. The search order is `last_grant`+1, +2, +3, +4 (mod 4), and the first non-empty lane wins.
- Pop: occurs when `ready_in`=1 and at least one candidate exists. The winner's head byte is registered into `data_out`, `out_lane` takes the winner index, `valid_out`=1, the read pointer advances, and `last_grant` takes the winner index.
- No pop (`ready_in`=0 or no candidate): `valid_out`=0. `data_out` and `out_lane` hold their previous values. `last_grant` is unchanged.
- At most one pop per cycle across all lanes. All four lanes may write in the same cycle.
- Flags `empty` and `almost_full` are combinational from the registered counts. `idle` = &`empty` & ~`valid_out`.

## Timing
- Reset values (edge with `reset`=1):
  - all pointers and counts 0;
  - `data_out`=0, `valid_out`=0, `out_lane`=0;
  - `last_grant`=3, so lane 0 has first priority;
  - `overflow`=4'b0000, `empty`=4'b1111, `almost_full`=4'b0000, `idle`=1.
- Reset mid-operation flushes all buffered bytes. Input valids during the reset cycle are ignored.
- No fall-through:
  - A byte written at edge k becomes a pop candidate at edge k+1.
  - It is visible on `data_out` after edge k+1.
  - Minimum latency is therefore 2 edges from input strobe to `valid_out`.
- An empty lane that writes and is otherwise eligible is not popped in the same cycle.
- Sustained throughput: one output byte per cycle while `ready_in`=1 and any lane holds data.
- Fairness: with all four lanes continuously non-empty, grants go 0,1,2,3,0,… A lane waits at most 3 pops.

## Test plan
- Reset then idle:
  - Stimulus: hold `reset` 2 cycles, then release with all valids=0 and `ready_in`=1.
  - Required response: `valid_out`=0, `empty`=4'b1111, `idle`=1, `data_out`=0.
- Single-lane latency:
  - Stimulus: `L1_in2`=8'hA5 with `L1_valid2`=1 for one cycle at edge k, `ready_in`=1.
  - Required response: after edge k+1, `data_out`=8'hA5, `out_lane`=2, `valid_out`=1 for exactly one cycle. `idle` returns to 1.
- Round-robin:
  - Stimulus: write lane0=8'h10, lane1=8'h11, lane2=8'h12, lane3=8'h13 in the same cycle, then hold `ready_in`=1.
  - Required response: outputs 8'h10, 8'h11, 8'h12, 8'h13 on consecutive cycles, with `out_lane` 0,1,2,3.
- Backpressure and full:
  - Stimulus: `ready_in`=0 and 5 consecutive writes 8'h01..8'h05 on lane 1 (`DEPTH`=4).
  - Required response: `almost_full[1]`=1 after the 3rd write. `overflow[1]`=1 after the 5th write and stays set. Raising `ready_in` then yields 01,02,03,04; 05 is lost.
- Full with simultaneous push and pop:
  - Stimulus: lane 0 full with 8'hB0..8'hB3, then `ready_in`=1 and `L1_valid0`=1 with 8'hB4 in the same cycle.
  - Required response: 8'hB0 is output, count stays 4, `overflow[0]` stays 0, and the later outputs are B1,B2,B3,B4.
- Reset mid-stream:
  - Stimulus: assert `reset` for one cycle while lanes 0 and 3 hold 2 bytes each.
  - Required response: next cycle `empty`=4'b1111 and `valid_out`=0. The next write to lane 3 is granted ahead of lane 0 only if lane 0 is empty, since `last_grant` has been reset to 3.
